cc_flags: RTL

Condition-code generator that feeds the branch-decision logic. It accepts signed 16-bit compare operands from the execute stage and computes the difference in a two-stage pipeline. It then holds the six condition flags (EQ, LT, GT, LE, GE, NE) in a register until the next compare commits. It also raises a stall toward decode while a branch asks for flags that are still in flight, and it counts those stall cycles.

---
 rtl/cc_pkg.sv | 23 ++
 rtl/cc_compare.sv | 28 ++
 rtl/cc_flags.sv | 85 ++++++++
 3 files changed

// File: rtl/cc_pkg.sv
// Shared types and constants for the condition-code generator.
package cc_pkg;

  parameter int unsigned DataWDefault = 16;

  // Packed so that bit 0 is LT; a 3-bit branch condition field indexes it directly.
  typedef struct packed {
    logic ne;
    logic eq;
    logic ge;
    logic le;
    logic gt;
    logic lt;
  } flags_t;

  localparam logic [2:0] CondLt = 3'd0;
  localparam logic [2:0] CondGt = 3'd1;
  localparam logic [2:0] CondLe = 3'd2;
  localparam logic [2:0] CondGe = 3'd3;
  localparam logic [2:0] CondEq = 3'd4;
  localparam logic [2:0] CondNe = 3'd5;

endpackage

// File: rtl/cc_compare.sv
// Maps a sign-extended difference to the six condition flags.
module cc_compare
  import cc_pkg::*;
#(
  parameter int unsigned DATA_W = DataWDefault
) (
  input  logic [DATA_W:0] diff,
  output flags_t          flags
);

  logic lt;
  logic eq;

  // diff is one bit wider than the operands, so its MSB is the true sign.
  assign lt = diff[DATA_W];
  assign eq = (diff == '0);

  always_comb begin
    flags    = '0;
    flags.lt = lt;
    flags.eq = eq;
    flags.gt = ~lt & ~eq;
    flags.le = lt | eq;
    flags.ge = ~lt;
    flags.ne = ~eq;
  end

endmodule

// File: rtl/cc_flags.sv
// Two-stage compare pipeline holding branch condition flags, with decode stall and stall counter.
module cc_flags
  import cc_pkg::*;
#(
  parameter int unsigned DATA_W = DataWDefault,
  parameter int unsigned CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cmp_valid,
  input  logic [DATA_W-1:0] cmp_a,
  input  logic [DATA_W-1:0] cmp_b,
  input  logic              flush,
  input  logic              br_query,
  output logic              EQ,
  output logic              LT,
  output logic              GT,
  output logic              LE,
  output logic              GE,
  output logic              NE,
  output logic              flags_valid,
  output logic              br_stall,
  output logic [CNT_W-1:0]  stall_cnt
);

  logic [DATA_W:0]  diff_d;
  logic [DATA_W:0]  diff_q;
  logic             s1_valid_q;
  flags_t           cmp_flags;
  flags_t           flags_q;
  logic             flags_valid_q;
  logic [CNT_W-1:0] stall_cnt_q;

  assign diff_d = {cmp_a[DATA_W-1], cmp_a} - {cmp_b[DATA_W-1], cmp_b};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q <= 1'b0;
      diff_q     <= '0;
    end else begin
      s1_valid_q <= cmp_valid & ~flush;
      if (cmp_valid && !flush) begin
        diff_q <= diff_d;
      end
    end
  end

  cc_compare #(
    .DATA_W (DATA_W)
  ) u_compare (
    .diff  (diff_q),
    .flags (cmp_flags)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      flags_q       <= '0;
      flags_valid_q <= 1'b0;
    end else if (s1_valid_q && !flush) begin
      flags_q       <= cmp_flags;
      flags_valid_q <= 1'b1;
    end
  end

  // Flags are stale while any compare is in stage 1 or entering it.
  assign br_stall = br_query & ~flush & (cmp_valid | s1_valid_q);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt_q <= '0;
    end else if (br_stall && (stall_cnt_q != '1)) begin
      stall_cnt_q <= stall_cnt_q + 1'b1;
    end
  end

  assign LT          = flags_q.lt;
  assign EQ          = flags_q.eq;
  assign GT          = flags_q.gt;
  assign LE          = flags_q.le;
  assign GE          = flags_q.ge;
  assign NE          = flags_q.ne;
  assign flags_valid = flags_valid_q;
  assign stall_cnt   = stall_cnt_q;

endmodule
